// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (port 0) and the
// debug/loader port (port 1): fixed priority to port 0, bounded by a starvation counter.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

  logic [7:0]  wcnt;
  logic [1:0]  gnt, we, legal, rvalid, err;
  logic [31:0] rdata_q [2];

  assign we       = {p1_we, p0_we};
  assign legal[0] = (p0_addr[31:12] == 20'd0) && (p0_addr[1:0] == 2'd0);
  assign legal[1] = (p1_addr[31:12] == 20'd0) && (p1_addr[1:0] == 2'd0);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    gnt       = 2'b00;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (p1_req && (!p0_req || wcnt == MAX_WAIT_W)) gnt[1] = 1'b1;
      else if (p0_req)                                gnt[0] = 1'b1;
    end
    // Illegal addresses still appear on the bus but can never write.
    if (gnt[0]) begin
      mem_we    = p0_we & legal[0];
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (gnt[1]) begin
      mem_we    = p1_we & legal[1];
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt       <= '0;
      rvalid     <= '0;
      err        <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rvalid[i] <= gnt[i] & (~we[i] | ~legal[i]);
        err[i]    <= gnt[i] & ~legal[i];
        if (gnt[i] && !legal[i])  rdata_q[i] <= '0;
        else if (gnt[i] && !we[i]) rdata_q[i] <= mem_rdata;
      end
      if (p1_req && !gnt[1]) begin
        if (wcnt != MAX_WAIT_W) wcnt <= wcnt + 8'd1;
      end else begin
        wcnt <= '0;
      end
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_err    = err[0];
  assign p1_err    = err[1];
  assign p0_rdata  = rdata_q[0];
  assign p1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1024-word behavioural memory behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [1024];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
  endtask

  // Inputs change at the falling edge; registered outputs are sampled 1ns after the rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic to_negedge();
    @(negedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | 32'(i);
    rst = 1'b0;
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    next_cycle();
    check("idle p0_gnt", {31'd0, p0_gnt}, 32'd0);
    check("idle p1_gnt", {31'd0, p1_gnt}, 32'd0);
    check("idle p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    check("idle p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    check("idle p0_err", {31'd0, p0_err}, 32'd0);
    check("idle p1_err", {31'd0, p1_err}, 32'd0);
    check("idle p0_rdata", p0_rdata, 32'd0);
    check("idle p1_rdata", p1_rdata, 32'd0);
    check("idle mem_we", {31'd0, mem_we}, 32'd0);
    check("idle mem_addr", mem_addr, 32'd0);
    check("idle mem_wdata", mem_wdata, 32'd0);

    // Port 0 write then read
    @(negedge clk); drive0(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF); #1;
    check("p0 wr gnt", {31'd0, p0_gnt}, 32'd1);
    check("p0 wr mem_we", {31'd0, mem_we}, 32'd1);
    check("p0 wr mem_addr", mem_addr, 32'h40);
    check("p0 wr mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    check("p0 wr rvalid", {31'd0, p0_rvalid}, 32'd0);
    @(negedge clk); drive0(1'b1, 1'b0, 32'h40, 32'h0); #1;
    check("p0 rd gnt", {31'd0, p0_gnt}, 32'd1);
    check("p0 rd mem_we", {31'd0, mem_we}, 32'd0);
    next_cycle();
    check("p0 rd rvalid", {31'd0, p0_rvalid}, 32'd1);
    check("p0 rd rdata", p0_rdata, 32'hDEAD_BEEF);
    check("p0 rd err", {31'd0, p0_err}, 32'd0);
    @(negedge clk); drive0(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    check("p0 rvalid pulse", {31'd0, p0_rvalid}, 32'd0);
    check("p0 rdata hold", p0_rdata, 32'hDEAD_BEEF);

    // Contention: p1 granted on every ninth cycle
    @(negedge clk);
    drive0(1'b1, 1'b0, 32'h100, 32'h0);
    drive1(1'b1, 1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 18; i++) begin
      #1;
      check($sformatf("cont p0_gnt c%0d", i + 1), {31'd0, p0_gnt}, (i % 9 == 8) ? 32'd0 : 32'd1);
      check($sformatf("cont p1_gnt c%0d", i + 1), {31'd0, p1_gnt}, (i % 9 == 8) ? 32'd1 : 32'd0);
      check($sformatf("cont mem_addr c%0d", i + 1), mem_addr, (i % 9 == 8) ? 32'h200 : 32'h100);
      next_cycle();
      check($sformatf("cont p1_rvalid c%0d", i + 1), {31'd0, p1_rvalid}, (i % 9 == 8) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("cont p1_rdata", p1_rdata, 32'h1000_0080);
    check("cont p0_rdata", p0_rdata, 32'h1000_0040);
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);

    // Bad addresses on port 1
    to_negedge();
    @(negedge clk); drive1(1'b1, 1'b1, 32'h0000_1000, 32'h5555_AAAA); #1;
    check("bad wr gnt", {31'd0, p1_gnt}, 32'd1);
    check("bad wr mem_we", {31'd0, mem_we}, 32'd0);
    check("bad wr mem_addr", mem_addr, 32'h0000_1000);
    next_cycle();
    check("bad wr rvalid", {31'd0, p1_rvalid}, 32'd1);
    check("bad wr err", {31'd0, p1_err}, 32'd1);
    check("bad wr rdata", p1_rdata, 32'd0);
    @(negedge clk); drive1(1'b1, 1'b0, 32'h0000_0042, 32'h0); #1;
    check("bad rd mem_we", {31'd0, mem_we}, 32'd0);
    next_cycle();
    check("bad rd rvalid", {31'd0, p1_rvalid}, 32'd1);
    check("bad rd err", {31'd0, p1_err}, 32'd1);
    check("bad rd rdata", p1_rdata, 32'd0);
    // Highest legal word
    @(negedge clk); drive1(1'b1, 1'b0, 32'h0000_0FFC, 32'h0);
    next_cycle();
    check("top rd err", {31'd0, p1_err}, 32'd0);
    check("top rd rdata", p1_rdata, 32'h1000_03FF);
    @(negedge clk); drive1(1'b0, 1'b0, 32'h0, 32'h0); drive0(1'b1, 1'b0, 32'h0, 32'h0);
    next_cycle();
    check("word0 unchanged", p0_rdata, 32'h1000_0000);
    @(negedge clk); drive0(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset mid-read
    to_negedge();
    @(negedge clk); drive0(1'b1, 1'b0, 32'h40, 32'h0); #1;
    check("rst rd gnt", {31'd0, p0_gnt}, 32'd1);
    #2 rst = 1'b0; #1;
    check("rst gnt forced", {31'd0, p0_gnt}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst p0_rdata", p0_rdata, 32'd0);
    next_cycle();
    check("rst no rvalid", {31'd0, p0_rvalid}, 32'd0);
    @(negedge clk); drive0(1'b0, 1'b0, 32'h0, 32'h0); rst = 1'b1;
    next_cycle();
    check("rst rel rvalid", {31'd0, p0_rvalid}, 32'd0);
    check("rst rel rdata", p0_rdata, 32'd0);

    // Alternating sole requesters
    @(negedge clk); drive1(1'b1, 1'b1, 32'hA0, 32'h0000_0002); #1;
    check("alt p1 gnt", {31'd0, p1_gnt}, 32'd1);
    @(negedge clk); drive1(1'b0, 1'b0, 32'h0, 32'h0); drive0(1'b1, 1'b0, 32'hA0, 32'h0); #1;
    check("alt p0 gnt", {31'd0, p0_gnt}, 32'd1);
    next_cycle();
    check("alt p0 rvalid", {31'd0, p0_rvalid}, 32'd1);
    check("alt p0 rdata", p0_rdata, 32'h0000_0002);
    @(negedge clk); drive0(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
